// File: rtl/instr_encoder.sv
// RV32I field-to-word encoder: packs decoded fields into a 32-bit instruction and streams it to IMEM with an auto-incrementing address.
// Optional build macro INSTR_ENC_ALIGN_CHK_EN drops B/J bundles whose immediate is not 2-byte aligned.
module instr_encoder #(
   parameter int                DEPTH     = 4,
   parameter int                ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        fmt,
   input  logic [6:0]        opcode,
   input  logic [4:0]        rd,
   input  logic [4:0]        rs1,
   input  logic [4:0]        rs2,
   input  logic [2:0]        funct3,
   input  logic [6:0]        funct7,
   input  logic [31:0]       imm,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_data,
   output logic [ADDR_W-1:0] out_addr,
   output logic              err,
   output logic [ADDR_W-1:0] count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [31:0]       mem_q [DEPTH];
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] count_q, count_d;
   logic              err_q, err_d;

   logic [31:0] word;
   logic        legal;
   logic        accept, push, pop, not_empty;

   always_comb begin
      word  = '0;
      legal = 1'b1;
      case (fmt)
         3'd0: word = {funct7, rs2, rs1, funct3, rd, opcode};
         3'd1: word = {imm[11:0], rs1, funct3, rd, opcode};
         3'd2: word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
         3'd3: word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
         3'd4: word = {imm[31:12], rd, opcode};
         3'd5: word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
         default: legal = 1'b0;
      endcase
`ifdef INSTR_ENC_ALIGN_CHK_EN
      // Branch/jump targets must be halfword aligned; JALR (I-format) is exempt.
      if ((fmt == 3'd3 || fmt == 3'd5) && imm[0]) legal = 1'b0;
`endif
   end

   // in_ready comes from registered occupancy only, never from out_ready.
   assign not_empty = (cnt_q != '0);
   assign in_ready  = (cnt_q != FULL_CNT) && !start;
   assign accept    = in_valid && in_ready;
   assign push      = accept && legal;
   assign pop       = not_empty && out_ready && !start;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      count_d  = count_q;
      err_d    = accept && !legal;
      if (start) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
         addr_d   = start_addr & ~ADDR_W'(3);
         count_d  = '0;
         err_d    = 1'b0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            addr_d   = addr_q + ADDR_W'(4);
            count_d  = count_q + ADDR_W'(1);
         end
         case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         addr_q   <= BASE_ADDR;
         count_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         count_q  <= count_d;
         err_q    <= err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= word;
   end

   // Gate the head with occupancy so stale or unwritten entries never leak out.
   assign out_valid = not_empty;
   assign out_data  = not_empty ? mem_q[rd_ptr_q] : 32'h0;
   assign out_addr  = addr_q;
   assign err       = err_q;
   assign count     = count_q;

endmodule
